// File: rtl/reg16_shift_reader_pkg.sv
// Shared types and constants for the 16-bit serial reader.
// Optional feature macro: REG16_SHIFT_READER_PARITY_EN (appends an even-parity bit).
package lc3_serial_pkg;

  localparam int WORD_W           = 16;
  localparam int FRAME_LEN_PLAIN  = 16;
  localparam int FRAME_LEN_PARITY = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Even parity over a captured word: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/reg16_bit_timer.sv
// Bit-period counter: produces a Tick on the last cycle of each serial bit.
// Counting pauses whenever Enable is low, so a stalled bit keeps its elapsed time.
module reg16_bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  input  logic Enable,
  output logic Tick
);

  localparam logic [7:0] LAST_CNT = 8'(BIT_CYCLES - 1);

  logic [7:0] cnt;

  assign Tick = Enable && (cnt == LAST_CNT);

  // Count enabled cycles within a bit period; wrap to zero when the bit completes.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt <= 8'd0;
    end else if (Clear) begin
      cnt <= 8'd0;
    end else if (Enable) begin
      cnt <= Tick ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/reg16_shift_reader.sv
// Parallel-to-serial reader: captures a 16-bit word and emits it MSB first,
// holding each bit for BIT_CYCLES enabled cycles, with backpressure via SReady.
// Optional feature macro: REG16_SHIFT_READER_PARITY_EN (17th even-parity bit).
module reg16_shift_reader
  import lc3_serial_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [WORD_W-1:0] D,
  input  logic              Load,
  input  logic              SReady,
  output logic              Ready,
  output logic              SOut,
  output logic              SValid,
  output logic              SLast,
  output logic              Done
);

`ifdef REG16_SHIFT_READER_PARITY_EN
  localparam int FRAME_LEN = FRAME_LEN_PARITY;
`else
  localparam int FRAME_LEN = FRAME_LEN_PLAIN;
`endif

  localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [FRAME_LEN-1:0]   shreg;
  logic [4:0]             bit_idx;
  logic                   capture;
  logic                   tick;
  logic                   advance;
  logic                   last_bit;
  logic                   timer_en;

  assign capture  = Ready && Load;
  assign timer_en = (state == SHIFT) && SReady;
  assign advance  = (state == SHIFT) && tick;
  assign last_bit = (bit_idx == LAST_IDX);
  assign SOut     = SValid & shreg[FRAME_LEN-1];

  reg16_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_timer (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clear  (capture),
    .Enable (timer_en),
    .Tick   (tick)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; DONE lasts one cycle and can accept a new Load.
  always_comb begin
    state_nxt = state;
    Ready     = 1'b0;
    SValid    = 1'b0;
    SLast     = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        Ready = 1'b1;
        if (Load) state_nxt = SHIFT;
      end
      SHIFT: begin
        SValid = 1'b1;
        SLast  = last_bit;
        if (tick && last_bit) state_nxt = DONE;
      end
      DONE: begin
        Ready     = 1'b1;
        Done      = 1'b1;
        state_nxt = Load ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register: load on capture (parity appended when enabled), shift left per completed bit.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      shreg <= '0;
    end else if (capture) begin
`ifdef REG16_SHIFT_READER_PARITY_EN
      shreg <= {D, even_parity(D)};
`else
      shreg <= D;
`endif
    end else if (advance) begin
      shreg <= {shreg[FRAME_LEN-2:0], 1'b0};
    end
  end

  // Bit index within the frame, used to flag the final bit.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bit_idx <= 5'd0;
    end else if (capture) begin
      bit_idx <= 5'd0;
    end else if (advance) begin
      bit_idx <= bit_idx + 5'd1;
    end
  end

endmodule

// File: tb/tb_reg16_shift_reader.sv
// Directed self-checking bench for reg16_shift_reader (BIT_CYCLES=1 and =4 instances).
module tb_reg16_shift_reader;

`ifdef REG16_SHIFT_READER_PARITY_EN
  localparam int FW = 17;
`else
  localparam int FW = 16;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] D = 16'h0000;
  logic        Load = 1'b0, SReady = 1'b1;
  logic        Load4 = 1'b0, SReady4 = 1'b1;
  logic        Ready, SOut, SValid, SLast, Done;
  logic        Ready4, SOut4, SValid4, SLast4, Done4;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  reg16_shift_reader #(.BIT_CYCLES(1)) dut (
    .Clk(Clk), .Reset(Reset), .D(D), .Load(Load), .SReady(SReady),
    .Ready(Ready), .SOut(SOut), .SValid(SValid), .SLast(SLast), .Done(Done)
  );

  reg16_shift_reader #(.BIT_CYCLES(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .D(D), .Load(Load4), .SReady(SReady4),
    .Ready(Ready4), .SOut(SOut4), .SValid(SValid4), .SLast(SLast4), .Done(Done4)
  );

  // Expected serial bit i of a frame built from word w (bit 16 is even parity).
  function automatic logic exp_bit(input logic [15:0] w, input int i);
    if (i < 16) return w[15-i];
    return ^w;
  endfunction

  task automatic test_reset();
    Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if (Ready !== 1'b1 || SOut !== 1'b0 || SValid !== 1'b0 || SLast !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs ready=%b sout=%b svalid=%b slast=%b done=%b want 1 0 0 0 0",
               Ready, SOut, SValid, SLast, Done);
    end
    checks++;
    if (Ready4 !== 1'b1 || SValid4 !== 1'b0 || Done4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs4 ready=%b svalid=%b done=%b want 1 0 0", Ready4, SValid4, Done4);
    end
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_basic();
    logic [15:0] w;
    logic [15:0] obs;
    w = 16'hA5C3;
    obs = '0;
    D = w; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    for (int i = 0; i < FW; i++) begin
      if (i < 16) obs = {obs[14:0], SOut};
      checks++;
      if (SValid !== 1'b1 || SOut !== exp_bit(w, i) || SLast !== (i == FW-1) || Ready !== 1'b0 || Done !== 1'b0) begin
        failures++;
        $display("FAIL basic_bit%0d sout=%b svalid=%b slast=%b ready=%b done=%b want sout=%b svalid=1 slast=%b ready=0 done=0",
                 i, SOut, SValid, SLast, Ready, Done, exp_bit(w, i), (i == FW-1));
      end
      @(negedge Clk);
    end
    checks++;
    if (obs !== 16'b1010010111000011) begin
      failures++;
      $display("FAIL basic_sequence got=%b want=%b", obs, 16'b1010010111000011);
    end
    checks++;
    if (Done !== 1'b1 || Ready !== 1'b1 || SValid !== 1'b0 || SLast !== 1'b0) begin
      failures++;
      $display("FAIL basic_done done=%b ready=%b svalid=%b slast=%b want 1 1 0 0", Done, Ready, SValid, SLast);
    end
    @(negedge Clk);
    checks++;
    if (Done !== 1'b0 || Ready !== 1'b1 || SValid !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle done=%b ready=%b svalid=%b want 0 1 0", Done, Ready, SValid);
    end
  endtask

  task automatic test_stall();
    logic [15:0] w;
    w = 16'h8001;
    D = w; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    for (int i = 0; i < FW; i++) begin
      checks++;
      if (SValid !== 1'b1 || SOut !== exp_bit(w, i) || SLast !== (i == FW-1) || Done !== 1'b0) begin
        failures++;
        $display("FAIL stall_bit%0d sout=%b svalid=%b slast=%b done=%b want sout=%b svalid=1 slast=%b done=0",
                 i, SOut, SValid, SLast, Done, exp_bit(w, i), (i == FW-1));
      end
      if (i == 2) begin
        SReady = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge Clk);
          checks++;
          if (SValid !== 1'b1 || SOut !== exp_bit(w, 2) || SLast !== 1'b0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold%0d sout=%b svalid=%b slast=%b done=%b want sout=%b svalid=1 slast=0 done=0",
                     s, SOut, SValid, SLast, Done, exp_bit(w, 2));
          end
        end
        SReady = 1'b1;
      end
      @(negedge Clk);
    end
    checks++;
    if (Done !== 1'b1 || Ready !== 1'b1 || SValid !== 1'b0) begin
      failures++;
      $display("FAIL stall_done done=%b ready=%b svalid=%b want 1 1 0", Done, Ready, SValid);
    end
    @(negedge Clk);
  endtask

  task automatic test_timing();
    logic [15:0] w;
    int bad;
    w = 16'hFFFF;
    bad = 0;
    D = w; Load4 = 1'b1;
    @(negedge Clk);
    Load4 = 1'b0;
    for (int c = 0; c < FW*4; c++) begin
      checks++;
      if (SValid4 !== 1'b1 || SOut4 !== exp_bit(w, c/4) || SLast4 !== ((c/4) == FW-1) || Done4 !== 1'b0) begin
        failures++;
        $display("FAIL timing_cycle%0d sout=%b svalid=%b slast=%b done=%b want sout=%b svalid=1 slast=%b done=0",
                 c+1, SOut4, SValid4, SLast4, Done4, exp_bit(w, c/4), ((c/4) == FW-1));
      end
      @(negedge Clk);
    end
    checks++;
    if (Done4 !== 1'b1 || Ready4 !== 1'b1 || SValid4 !== 1'b0 || SLast4 !== 1'b0) begin
      failures++;
      $display("FAIL timing_done done=%b ready=%b svalid=%b slast=%b want 1 1 0 0", Done4, Ready4, SValid4, SLast4);
    end
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] w1, w2;
    w1 = 16'h1234;
    w2 = 16'h0F0F;
    D = w1; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    for (int i = 0; i < FW; i++) begin
      checks++;
      if (SValid !== 1'b1 || SOut !== exp_bit(w1, i) || SLast !== (i == FW-1) || Ready !== 1'b0) begin
        failures++;
        $display("FAIL busy_bit%0d sout=%b svalid=%b slast=%b ready=%b want sout=%b svalid=1 slast=%b ready=0",
                 i, SOut, SValid, SLast, Ready, exp_bit(w1, i), (i == FW-1));
      end
      if (i == 5) begin D = 16'hFFFF; Load = 1'b1; end
      if (i == 6) Load = 1'b0;
      @(negedge Clk);
    end
    checks++;
    if (Done !== 1'b1 || Ready !== 1'b1) begin
      failures++;
      $display("FAIL busy_done done=%b ready=%b want 1 1", Done, Ready);
    end
    D = w2; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    for (int i = 0; i < FW; i++) begin
      checks++;
      if (SValid !== 1'b1 || SOut !== exp_bit(w2, i) || SLast !== (i == FW-1) || Done !== 1'b0) begin
        failures++;
        $display("FAIL b2b_bit%0d sout=%b svalid=%b slast=%b done=%b want sout=%b svalid=1 slast=%b done=0",
                 i, SOut, SValid, SLast, Done, exp_bit(w2, i), (i == FW-1));
      end
      @(negedge Clk);
    end
    checks++;
    if (Done !== 1'b1 || SValid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done done=%b svalid=%b want 1 0", Done, SValid);
    end
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w;
    w = 16'h00FF;
    D = w; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge Clk);
    checks++;
    if (SValid !== 1'b1 || SOut !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_pre svalid=%b sout=%b want 1 0", SValid, SOut);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (Ready !== 1'b1 || SOut !== 1'b0 || SValid !== 1'b0 || SLast !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_outputs ready=%b sout=%b svalid=%b slast=%b done=%b want 1 0 0 0 0",
               Ready, SOut, SValid, SLast, Done);
    end
    @(negedge Clk);
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      checks++;
      if (Done !== 1'b0 || Ready !== 1'b1 || SValid !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_idle%0d done=%b ready=%b svalid=%b want 0 1 0", k, Done, Ready, SValid);
      end
    end
    Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    for (int i = 0; i < FW; i++) begin
      checks++;
      if (SValid !== 1'b1 || SOut !== exp_bit(w, i) || SLast !== (i == FW-1)) begin
        failures++;
        $display("FAIL rstmid_bit%0d sout=%b svalid=%b slast=%b want sout=%b svalid=1 slast=%b",
                 i, SOut, SValid, SLast, exp_bit(w, i), (i == FW-1));
      end
      @(negedge Clk);
    end
    checks++;
    if (Done !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_done done=%b want 1", Done);
    end
    @(negedge Clk);
  endtask

`ifdef REG16_SHIFT_READER_PARITY_EN
  task automatic test_parity();
    logic [15:0] words [2];
    logic        pbit  [2];
    words[0] = 16'h0007; pbit[0] = 1'b1;
    words[1] = 16'h0003; pbit[1] = 1'b0;
    for (int t = 0; t < 2; t++) begin
      D = words[t]; Load = 1'b1;
      @(negedge Clk);
      Load = 1'b0;
      for (int i = 0; i < 15; i++) @(negedge Clk);
      checks++;
      if (SValid !== 1'b1 || SOut !== words[t][0] || SLast !== 1'b0) begin
        failures++;
        $display("FAIL parity_d0_%0d sout=%b svalid=%b slast=%b want sout=%b svalid=1 slast=0",
                 t, SOut, SValid, SLast, words[t][0]);
      end
      @(negedge Clk);
      checks++;
      if (SValid !== 1'b1 || SOut !== pbit[t] || SLast !== 1'b1) begin
        failures++;
        $display("FAIL parity_bit_%0d sout=%b svalid=%b slast=%b want sout=%b svalid=1 slast=1",
                 t, SOut, SValid, SLast, pbit[t]);
      end
      @(negedge Clk);
      checks++;
      if (Done !== 1'b1) begin
        failures++;
        $display("FAIL parity_done_%0d done=%b want 1", t, Done);
      end
      @(negedge Clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_timing();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef REG16_SHIFT_READER_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
